fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction-fetch stage with a small prefetch queue. It sits between the combinational instruction memory and the main decoder.
- Owns the fetch PC and drives the instruction-memory address.
- Buffers up to DEPTH fetched {pc, instr} pairs.
- Presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream, which flush the queue.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000: fetch byte address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_addr  out  32  byte address of word being fetched; memory indexes with imem_addr[31:2]
- imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle
- out_valid  out  1  head entry valid
- out_instr  out  32  head instruction
- out_pc  out  32  byte address of head instruction
- out_ready  in  1  decoder accepts head this cycle
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch byte address
- count  out  $clog2(DEPTH)+1  occupied entries

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset state: fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0.
  - Asynchronous: takes effect immediately, including mid-stream.
- imem_addr = fetch_pc, combinational.
- Head outputs:
  - out_valid = (count != 0).
  - Empty: out_instr=0 (NOP) and out_pc=0.
  - Otherwise: head entry straight from storage, no extra register.
- pop = out_valid & out_ready & !redirect_valid.
- push = !redirect_valid & (count < DEPTH | pop).
  - Full with a pop in the same cycle: push still allowed (simultaneous push/pop, count unchanged).
- On push:
  - Entry {fetch_pc, imem_rdata} written at the tail.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0).
- Full with no pop: no push; fetch_pc holds; imem_addr stable.
- count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - otherwise: unchanged.
- Read/write pointers wrap modulo DEPTH.
- Redirect has absolute priority:
  - At the edge: count <= 0, pointers <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned targets are silently aligned.
  - No push and no pop in that cycle; decode treats the head as squashed.
- Latency:
  - Instruction at address A: fetched in cycle N, visible at the head from cycle N+1.
  - Redirect asserted in cycle N: out_valid=0 in cycle N+1, target instruction at the head in cycle N+2 (one-bubble penalty).
- Throughput: one instruction per cycle with out_ready held high.
- Head output stability: out_instr and out_pc stay stable while out_valid=1 and out_ready=0.
- Pop on empty: impossible by construction.

Decomposition:
- Shared package:
  - NOP_INSTR = 32'h0.
  - PC_STEP = 4.
  - Entry typedef {pc[31:0], instr[31:0]} (64 bits).
  - RESET_PC default.
- One natural sub-module: fetch_fifo, a synchronous FIFO.
  - Parameters: WIDTH=64, DEPTH.
  - Ports: push, pop, flush, count, head.
- fetch_queue keeps fetch_pc, push/pop/redirect arbitration, and output muxing.

Test Plan:
1. Reset, memory word i = 32'h1000_0000+i, out_ready=1 -> out_pc 0,4,8,0xC… one per cycle, out_instr matching, out_valid high from the first edge after rst release.
2. out_ready=0 for 8 cycles -> count saturates at 4, imem_addr holds 0x10, out_pc holds 0. Then out_ready=1 -> pcs 0,4,8,0xC,0x10,0x14 with no gap or duplicate.
3. Queue full and out_ready=1 in the same cycle -> count stays 4, fetch_pc advances, head advances by one.
4. Queue holding 3 entries, redirect_valid=1 for one cycle with redirect_pc=0x40 -> next cycle count=0 and out_valid=0; the cycle after, out_pc=0x40. Repeat with redirect_pc=0x43 -> fetch at 0x40.
5. redirect_pc=0xFFFF_FFFC with out_ready=1 -> out_pc sequence 0xFFFF_FFFC, 0x0, 0x4.
6. Assert rst asynchronously between edges during streaming -> out_valid, count and imem_addr reset immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch stage and its prefetch FIFO.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched entries; flush empties it and takes priority over push/pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Full with push+pop writes the slot being read; the head moves on at the same edge.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, prefetches into a small queue,
// hands entries to decode over valid/ready and flushes on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    input  logic                   out_ready,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        out_valid  = (fifo_count != '0);
        pop        = out_valid & out_ready & ~redirect_valid;
        push       = ~redirect_valid & ((fifo_count < CNT_W'(DEPTH)) | pop);
        wr_entry   = '{pc: fetch_pc_q, instr: imem_rdata};
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        out_instr = out_valid ? head.instr : NOP_INSTR;
        out_pc    = out_valid ? head.pc    : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign count     = fifo_count;

    fetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched PCs plus the next PC to fetch.
    logic [31:0] mq[$];
    logic [31:0] m_pc = RESET_PC;
    bit m_pop, m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = (mq.size() < DEPTH) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("m_pc",    out_pc,    (mq.size() != 0) ? mq[0] : 32'h0);
        chk("m_instr", out_instr, (mq.size() != 0) ? mem_word(mq[0]) : 32'h0);
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_addr",  imem_addr, m_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_addr",  imem_addr, RESET_PC);
        chk("rst_pc",    out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Streaming with ready held high
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_valid", {31'b0, out_valid}, 32'h1);
            chk("t1_pc",    out_pc, 32'(i * 4));
            chk("t1_instr", out_instr, 32'h1000_0000 + 32'(i));
        end

        // Stall until full, then drain with no gap or duplicate
        #1 redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        tick();
        chk("t2_flush_count", 32'(count), 32'h0);
        chk("t2_flush_valid", {31'b0, out_valid}, 32'h0);
        #1 redirect_valid = 1'b0;
        repeat (8) tick();
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_hold_addr",  imem_addr, 32'h10);
        chk("t2_hold_pc",    out_pc, 32'h0);
        #1 out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t2_drain_pc", out_pc, 32'(k * 4));
            if (k == 1) begin
                chk("t3_full_pop_count", 32'(count), 32'd4);
                chk("t3_full_pop_addr",  imem_addr, 32'h14);
            end
        end

        // Redirect with three entries queued, aligned and misaligned targets
        #1 out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        #1 redirect_valid = 1'b0;
        repeat (3) tick();
        chk("t4_pre_count", 32'(count), 32'd3);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("t4_count", 32'(count), 32'h0);
        chk("t4_valid", {31'b0, out_valid}, 32'h0);
        chk("t4_addr",  imem_addr, 32'h40);
        #1 redirect_valid = 1'b0;
        tick();
        chk("t4_head_valid", {31'b0, out_valid}, 32'h1);
        chk("t4_head_pc",    out_pc, 32'h40);
        chk("t4_head_instr", out_instr, 32'h1000_0010);
        repeat (2) tick();
        chk("t4b_pre_count", 32'(count), 32'd3);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h43;
        tick();
        chk("t4b_addr",  imem_addr, 32'h40);
        chk("t4b_count", 32'(count), 32'h0);
        #1 redirect_valid = 1'b0;
        tick();
        chk("t4b_head_pc", out_pc, 32'h40);

        // PC wrap at the top of the address space
        #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
        tick();
        chk("t5_bubble", {31'b0, out_valid}, 32'h0);
        #1 redirect_valid = 1'b0;
        tick();
        chk("t5_pc0",    out_pc, 32'hFFFF_FFFC);
        chk("t5_instr0", out_instr, 32'h4FFF_FFFF);
        tick();
        chk("t5_pc1", out_pc, 32'h0);
        tick();
        chk("t5_pc2", out_pc, 32'h4);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            #1;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            tick();
        end
        #1 redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset between edges during streaming
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'b0, out_valid}, 32'h0);
        chk("t6_count", 32'(count), 32'h0);
        chk("t6_addr",  imem_addr, RESET_PC);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("t6_restart_valid", {31'b0, out_valid}, 32'h1);
        chk("t6_restart_pc",    out_pc, RESET_PC);
        tick();
        chk("t6_restart_pc1",   out_pc, RESET_PC + 32'd4);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
